// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage owning R15, one outstanding request, prefetch FIFO flushed on branch
module fetch_unit #(
    parameter int          QDEPTH   = 2,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [31:0] pc_in_i,
    output logic        pc_we_o,
    output logic [31:0] pc_wdata_o,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i,
    input  logic        branch_en_i,
    output logic        instr_valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    input  logic        instr_ready_i
);
    localparam int AW = $clog2(QDEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(QDEPTH);
    localparam logic [1:0] S_BOOT = 2'd0;
    localparam logic [1:0] S_IDLE = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_DROP = 2'd3;

    logic [1:0]    state_q, state_d;
    logic          mem_req_q, mem_req_d;
    logic [31:0]   mem_addr_q, mem_addr_d;
    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] rd_q, wr_q;
    logic [31:0]   data_q [QDEPTH];
    logic [31:0]   addr_q [QDEPTH];
    logic          issue, push, pop;

    assign issue = (state_q == S_IDLE) && !branch_en_i && (count_q < FULL);
    assign push  = (state_q == S_WAIT) && mem_ack_i && !branch_en_i;
    assign pop   = instr_ready_i && (count_q != '0);

    assign pc_we_o       = rst_n_i && !branch_en_i && ((state_q == S_BOOT) || push);
    assign pc_wdata_o    = (state_q == S_BOOT) ? RESET_PC : mem_addr_q + 32'd4;
    assign mem_req_o     = mem_req_q;
    assign mem_addr_o    = mem_addr_q;
    assign instr_valid_o = rst_n_i && (count_q != '0);
    assign instr_o       = data_q[rd_q];
    assign instr_pc_o    = addr_q[rd_q];

    // Fetch sequencing: a request, once raised, is held until acknowledged even across a branch
    always_comb begin
        state_d    = state_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        count_d    = branch_en_i ? '0 : count_q + CW'(push) - CW'(pop);
        case (state_q)
            S_BOOT: state_d = S_IDLE;
            S_IDLE: begin
                state_d    = issue ? S_WAIT : S_IDLE;
                mem_req_d  = issue;
                mem_addr_d = issue ? pc_in_i : mem_addr_q;
            end
            S_WAIT: begin
                state_d   = mem_ack_i ? S_IDLE : (branch_en_i ? S_DROP : S_WAIT);
                mem_req_d = !mem_ack_i;
            end
            default: begin
                state_d   = mem_ack_i ? S_IDLE : S_DROP;
                mem_req_d = !mem_ack_i;
            end
        endcase
    end

    // Control state and FIFO pointers; a branch empties the queue and beats any push or pop
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q    <= S_BOOT;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            count_q    <= '0;
            rd_q       <= '0;
            wr_q       <= '0;
        end else begin
            state_q    <= state_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            count_q    <= count_d;
            rd_q       <= branch_en_i ? '0 : (pop ? rd_q + AW'(1) : rd_q);
            wr_q       <= branch_en_i ? '0 : (push ? wr_q + AW'(1) : wr_q);
        end
    end

    // FIFO storage needs no reset; the count decides what is visible
    always_ff @(posedge clk_i) begin
        if (rst_n_i && push) begin
            data_q[wr_q] <= mem_rdata_i;
            addr_q[wr_q] <= mem_addr_q;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed vector table plus hand sequences for branch, wrap and reset corners
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        rst_n, pc_we, mem_req, mem_ack, branch_en, instr_valid, instr_ready;
    logic [31:0] pc_in, pc_wdata, mem_addr, mem_rdata, instr, instr_pc, tgt;
    int          total = 0;
    int          passed = 0;

    always #5 clk = ~clk;

    fetch_unit #(.QDEPTH(2), .RESET_PC(32'h0)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .pc_in_i(pc_in), .pc_we_o(pc_we), .pc_wdata_o(pc_wdata),
        .mem_req_o(mem_req), .mem_addr_o(mem_addr), .mem_ack_i(mem_ack), .mem_rdata_i(mem_rdata),
        .branch_en_i(branch_en), .instr_valid_o(instr_valid), .instr_o(instr), .instr_pc_o(instr_pc),
        .instr_ready_i(instr_ready)
    );

    typedef struct {
        logic        rst, ack, br, rdy;
        logic [31:0] rdata, tg;
        logic        we;
        logic [31:0] wdata;
        logic        req;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] ins, ipc;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic drive(input logic r, input logic a, input logic b, input logic y,
                         input logic [31:0] d, input logic [31:0] t);
        rst_n = r; mem_ack = a; branch_en = b; instr_ready = y; mem_rdata = d; tgt = t;
        #1;
    endtask

    // register bank model: ALU branch write has priority over the fetch PC write
    task automatic tick;
        logic [31:0] nxt;
        nxt = branch_en ? tgt : (pc_we ? pc_wdata : pc_in);
        @(posedge clk);
        #1;
        pc_in = nxt;
    endtask

    vec_t v [19];

    initial begin
        v[0]  = '{0,0,0,0,32'h0,32'h0,         0,32'h0,  0,32'h0,  0,32'h0,32'h0};
        v[1]  = '{1,0,0,0,32'h0,32'h0,         1,32'h0,  0,32'h0,  0,32'h0,32'h0};
        v[2]  = '{1,0,0,0,32'h0,32'h0,         0,32'h0,  0,32'h0,  0,32'h0,32'h0};
        v[3]  = '{1,1,0,0,32'hA0A0A0A0,32'h0,  1,32'h4,  1,32'h0,  0,32'h0,32'h0};
        v[4]  = '{1,1,0,0,32'h0,32'h0,         0,32'h0,  0,32'h0,  1,32'hA0A0A0A0,32'h0};
        v[5]  = '{1,1,0,0,32'hA1A1A1A1,32'h0,  1,32'h8,  1,32'h4,  1,32'hA0A0A0A0,32'h0};
        v[6]  = '{1,1,0,0,32'h0,32'h0,         0,32'h0,  0,32'h0,  1,32'hA0A0A0A0,32'h0};
        v[7]  = '{1,1,0,0,32'h0,32'h0,         0,32'h0,  0,32'h0,  1,32'hA0A0A0A0,32'h0};
        v[8]  = '{1,1,0,1,32'h0,32'h0,         0,32'h0,  0,32'h0,  1,32'hA0A0A0A0,32'h0};
        v[9]  = '{1,0,0,0,32'h0,32'h0,         0,32'h0,  0,32'h0,  1,32'hA1A1A1A1,32'h4};
        v[10] = '{1,0,1,0,32'h0,32'h100,       0,32'h0,  1,32'h8,  1,32'hA1A1A1A1,32'h4};
        v[11] = '{1,0,0,0,32'h0,32'h0,         0,32'h0,  1,32'h8,  0,32'h0,32'h0};
        v[12] = '{1,1,0,0,32'hBAD0BAD0,32'h0,  0,32'h0,  1,32'h8,  0,32'h0,32'h0};
        v[13] = '{1,0,0,0,32'h0,32'h0,         0,32'h0,  0,32'h0,  0,32'h0,32'h0};
        v[14] = '{1,0,0,0,32'h0,32'h0,         0,32'h0,  1,32'h100,0,32'h0,32'h0};
        v[15] = '{1,0,0,0,32'h0,32'h0,         0,32'h0,  1,32'h100,0,32'h0,32'h0};
        v[16] = '{1,0,0,0,32'h0,32'h0,         0,32'h0,  1,32'h100,0,32'h0,32'h0};
        v[17] = '{1,1,0,0,32'hE3A01005,32'h0,  1,32'h104,1,32'h100,0,32'h0,32'h0};
        v[18] = '{1,0,0,0,32'h0,32'h0,         0,32'h0,  0,32'h0,  1,32'hE3A01005,32'h100};

        pc_in = 32'hDEADBEEF;
        drive(0, 0, 0, 0, 32'h0, 32'h0);
        tick();
        chk("rst_addr", mem_addr, 32'h0);
        for (int i = 0; i < 19; i++) begin
            drive(v[i].rst, v[i].ack, v[i].br, v[i].rdy, v[i].rdata, v[i].tg);
            chk($sformatf("v%0d_we", i), {31'h0, pc_we}, {31'h0, v[i].we});
            if (v[i].we) chk($sformatf("v%0d_wdata", i), pc_wdata, v[i].wdata);
            chk($sformatf("v%0d_req", i), {31'h0, mem_req}, {31'h0, v[i].req});
            if (v[i].req) chk($sformatf("v%0d_addr", i), mem_addr, v[i].addr);
            chk($sformatf("v%0d_valid", i), {31'h0, instr_valid}, {31'h0, v[i].valid});
            if (v[i].valid) begin
                chk($sformatf("v%0d_instr", i), instr, v[i].ins);
                chk($sformatf("v%0d_ipc", i), instr_pc, v[i].ipc);
            end
            tick();
        end

        // branch coinciding with ack and pop
        drive(1, 1, 1, 1, 32'h11111111, 32'h300);
        chk("br_ack_we", {31'h0, pc_we}, 32'h0);
        chk("br_ack_req", {31'h0, mem_req}, 32'h1);
        tick();
        drive(1, 0, 0, 0, 32'h0, 32'h0);
        chk("br_ack_valid", {31'h0, instr_valid}, 32'h0);
        chk("br_ack_idle_req", {31'h0, mem_req}, 32'h0);
        tick();
        // branch during WAIT without ack, then a second branch while in DROP
        drive(1, 0, 1, 0, 32'h0, 32'h200);
        chk("br_tgt_req", {31'h0, mem_req}, 32'h1);
        chk("br_tgt_addr", mem_addr, 32'h300);
        chk("br_wait_we", {31'h0, pc_we}, 32'h0);
        tick();
        drive(1, 0, 1, 0, 32'h0, 32'h200);
        chk("drop_req", {31'h0, mem_req}, 32'h1);
        chk("drop_addr", mem_addr, 32'h300);
        tick();
        drive(1, 1, 0, 0, 32'hBADBAD00, 32'h0);
        chk("drop_ack_we", {31'h0, pc_we}, 32'h0);
        chk("drop_ack_req", {31'h0, mem_req}, 32'h1);
        tick();
        drive(1, 0, 0, 0, 32'h0, 32'h0);
        chk("drop_valid", {31'h0, instr_valid}, 32'h0);
        chk("drop_idle_req", {31'h0, mem_req}, 32'h0);
        tick();
        // ack plus branch to the top word, then fetch that word and check wrap
        drive(1, 1, 1, 0, 32'h77777777, 32'hFFFFFFFC);
        chk("target_req", {31'h0, mem_req}, 32'h1);
        chk("target_addr", mem_addr, 32'h200);
        chk("target_we", {31'h0, pc_we}, 32'h0);
        tick();
        drive(1, 0, 0, 0, 32'h0, 32'h0);
        chk("wrap_pre_valid", {31'h0, instr_valid}, 32'h0);
        tick();
        drive(1, 1, 0, 0, 32'h66666666, 32'h0);
        chk("wrap_addr", mem_addr, 32'hFFFFFFFC);
        chk("wrap_we", {31'h0, pc_we}, 32'h1);
        chk("wrap_wdata", pc_wdata, 32'h0);
        tick();
        drive(1, 0, 0, 0, 32'h0, 32'h0);
        chk("wrap_valid", {31'h0, instr_valid}, 32'h1);
        chk("wrap_instr", instr, 32'h66666666);
        chk("wrap_ipc", instr_pc, 32'hFFFFFFFC);
        tick();
        // reset while a request is outstanding
        drive(0, 0, 0, 0, 32'h0, 32'h0);
        chk("mid_rst_req_before", {31'h0, mem_req}, 32'h1);
        chk("mid_rst_we", {31'h0, pc_we}, 32'h0);
        tick();
        drive(1, 0, 0, 0, 32'h0, 32'h0);
        chk("reboot_req", {31'h0, mem_req}, 32'h0);
        chk("reboot_valid", {31'h0, instr_valid}, 32'h0);
        chk("reboot_we", {31'h0, pc_we}, 32'h1);
        chk("reboot_wdata", pc_wdata, 32'h0);
        tick();
        drive(1, 0, 0, 0, 32'h0, 32'h0);
        chk("reboot_idle_req", {31'h0, mem_req}, 32'h0);
        tick();
        drive(1, 0, 0, 0, 32'h0, 32'h0);
        chk("reboot_issue_req", {31'h0, mem_req}, 32'h1);
        chk("reboot_issue_addr", mem_addr, 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
